rv32_div_unit: RTL and testbench
================================

// Module: rv32_div_unit
// PURPOSE
//  Multi-cycle RV32M divide/remainder responder for the execute-stage ALU.
//  ALU issues DIV/DIVU/REM/REMU with a valid/ready request; unit runs a
//  restoring radix-2 divide, one quotient bit per aclk cycle.
//  Result is returned on a valid/ready response channel and held until taken.
// PARAMETERS
//  XLEN  32  operand/result width; iteration count equals XLEN
// PORTS
//  aclk        in   1     clock; all state changes on rising edge
//  rst_n       in   1     asynchronous active-low reset
//  flush       in   1     pipeline flush; abort any in-flight op
//  req_valid   in   1     request present
//  req_ready   out  1     unit can accept; = (state==IDLE) && !flush
//  func        in   3     funct3: x00 DIV, x01 DIVU, x10 REM, x11 REMU (bit2 ignored)
//  din1        in   XLEN  dividend
//  din2        in   XLEN  divisor
//  resp_valid  out  1     dout valid; = (state==DONE)
//  resp_ready  in   1     consumer takes result
//  dout        out  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU)
//  busy        out  1     state!=IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, dout=0, count=0, work regs=0;
//   resp_valid=0, busy=0, req_ready=1 once rst_n high. Reset mid-op drops op.
//  States: IDLE -> CALC -> DONE -> IDLE; IDLE -> DONE for special cases.
//  Accept: edge where req_valid && req_ready. Operands/func latched there;
//   din1/din2/func ignored at all other times.
//  Signed ops (DIV, REM): divide |din1| by |din2| as unsigned XLEN-bit;
//   |0x80000000| = 0x80000000 unsigned. Quotient negated if signs differ;
//   remainder takes sign of dividend. Unsigned ops use raw operands.
//  Special cases, resolved at accept edge, state -> DONE directly:
//   din2==0: quotient = all ones, remainder = din1 (signed and unsigned).
//   DIV/REM with din1=0x80000000, din2=all ones: quot=0x80000000, rem=0.
//   resp_valid high in the cycle following the accept edge.
//  Normal: accept edge E0 loads abs operands, count=XLEN, state=CALC.
//   Edges E1..E_XLEN each do one shift/compare/subtract, count decrements.
//   At E_XLEN final step plus sign fix written to dout, state=DONE;
//   resp_valid high for the first time after E_XLEN (latency XLEN cycles).
//  DONE: dout and resp_valid held stable until resp_valid && resp_ready;
//   that edge -> IDLE. req_ready=0 in CALC and DONE (no overlap); new
//   request accepted no earlier than the cycle after response handshake.
//  flush: in CALC or DONE, next edge -> IDLE, resp_valid=0, dout unchanged.
//   flush in IDLE blocks acceptance that cycle (flush wins over req_valid).
//   flush coincident with response handshake: -> IDLE, result counts taken.
//  dout changes only on entry to DONE or reset.
// TESTING
//  DIVU 100/7 -> dout=14 exactly 32 cycles after accept; REMU 100/7 -> 2.
//  DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF.
//  DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIVU 0/0 -> 0xFFFFFFFF; each
//   resp_valid 1 cycle after accept.
//  DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; DIVU same -> 0.
//  resp_ready low 10 cycles in DONE -> dout, resp_valid stable, req_ready=0;
//   back-to-back requests: 2nd accepted cycle after 1st handshake, correct.
//  flush at iteration 10, and rst_n pulse at iteration 20 -> IDLE,
//   resp_valid never rises; following DIVU 0xFFFFFFFF/3 -> 0x55555555.

Source files
------------

// File: rtl/rv32_div_unit.sv
// rtl/rv32_div_unit.sv - multi-cycle RV32M DIV/DIVU/REM/REMU unit, restoring radix-2
module rv32_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            aclk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      func,
    input  logic [XLEN-1:0] din1,
    input  logic [XLEN-1:0] din2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] dout,
    output logic            busy
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] rem_r;
    logic [XLEN-1:0] quo_r;
    logic [XLEN-1:0] dvsr_r;
    logic [XLEN-1:0] dout_r;
    logic            neg_q;
    logic            neg_r;
    logic            is_rem;
    logic            accept;

    // funct3 bit 2 only distinguishes MUL vs DIV groups upstream
    logic unused_func_bit;
    assign unused_func_bit = func[2];

    // Request decode: signed ops use magnitudes, sign fix applied at the end
    logic            signed_op;
    logic            rem_op;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] abs1;
    logic [XLEN-1:0] abs2;
    logic            div_zero;
    logic            ovf;
    logic [XLEN-1:0] special_res;

    assign signed_op = ~func[0];
    assign rem_op    = func[1];
    assign a_neg     = signed_op & din1[XLEN-1];
    assign b_neg     = signed_op & din2[XLEN-1];
    assign abs1      = a_neg ? -din1 : din1;
    assign abs2      = b_neg ? -din2 : din2;
    assign div_zero  = (din2 == '0);
    assign ovf       = signed_op && (din1 == {1'b1, {(XLEN-1){1'b0}}}) && (din2 == '1);
    // Overflow quotient is the most-negative value, which equals din1 itself
    assign special_res = div_zero ? (rem_op ? din1 : '1)
                                  : (rem_op ? '0 : din1);

    // One restoring step: shift in the next dividend bit, subtract if it fits
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic            q_bit;
    logic [XLEN-1:0] rem_nx;
    logic [XLEN-1:0] quo_nx;
    logic [XLEN-1:0] final_res;
    logic            last_step;

    assign shifted   = {rem_r, quo_r[XLEN-1]};
    assign diff      = shifted - {1'b0, dvsr_r};
    assign q_bit     = ~diff[XLEN];
    assign rem_nx    = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign quo_nx    = {quo_r[XLEN-2:0], q_bit};
    assign final_res = is_rem ? (neg_r ? -rem_nx : rem_nx)
                              : (neg_q ? -quo_nx : quo_nx);
    assign last_step = (count == CW'(1));

    // State register
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and handshake outputs; flush always wins
    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b1;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                busy      = 1'b0;
                req_ready = ~flush;
                accept    = req_valid & ~flush;
                if (accept) begin
                    state_nx = (div_zero || ovf) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_nx = S_IDLE;
                end else if (last_step) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                resp_valid = 1'b1;
                if (flush || resp_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Datapath: latch operands on accept, iterate in CALC, write dout on DONE entry
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            rem_r  <= '0;
            quo_r  <= '0;
            dvsr_r <= '0;
            dout_r <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            is_rem <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        is_rem <= rem_op;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        if (div_zero || ovf) begin
                            dout_r <= special_res;
                        end else begin
                            rem_r  <= '0;
                            quo_r  <= abs1;
                            dvsr_r <= abs2;
                            count  <= CW'(XLEN);
                        end
                    end
                end
                S_CALC: begin
                    if (!flush) begin
                        rem_r <= rem_nx;
                        quo_r <= quo_nx;
                        count <= count - 1'b1;
                        if (last_step) begin
                            dout_r <= final_res;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign dout = dout_r;

endmodule

// File: tb/tb_rv32_div_unit.sv
// tb/tb_rv32_div_unit.sv - directed vector bench for rv32_div_unit
module tb_rv32_div_unit;
    localparam logic [2:0] F_DIV  = 3'b000;
    localparam logic [2:0] F_DIVU = 3'b001;
    localparam logic [2:0] F_REM  = 3'b010;
    localparam logic [2:0] F_REMU = 3'b011;

    logic        aclk;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  func;
    logic [31:0] din1;
    logic [31:0] din2;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] dout;
    logic        busy;

    int errors = 0;
    int checks = 0;

    rv32_div_unit #(.XLEN(32)) dut (
        .aclk      (aclk),
        .rst_n     (rst_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .func      (func),
        .din1      (din1),
        .din2      (din2),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .dout      (dout),
        .busy      (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // lat = rising edges after the accept edge before resp_valid is seen
    typedef struct {
        string       name;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int n;
        @(negedge aclk);
        func      = f;
        din1      = a;
        din2      = b;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 50) chk("issue_timeout", 32'(n), 32'd0);
        @(posedge aclk);
        #1;
        req_valid = 1'b0;
        func      = 3'($urandom);
        din1      = $urandom;
        din2      = $urandom;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (!resp_valid && lat < 100) begin
            @(posedge aclk);
            #1;
            lat++;
        end
    endtask

    task automatic take();
        @(negedge aclk);
        resp_ready = 1'b1;
        @(posedge aclk);
        #1;
        resp_ready = 1'b0;
    endtask

    task automatic watch_no_resp(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge aclk);
            #1;
            if (resp_valid) seen++;
        end
        chk(name, 32'(seen), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        issue(v.f, v.a, v.b);
        wait_resp(lat);
        chk({v.name, "_lat"}, 32'(lat), 32'(v.lat));
        chk({v.name, "_dout"}, dout, v.exp);
        take();
        chk({v.name, "_idle"}, {31'd0, resp_valid | busy}, 32'd0);
    endtask

    initial begin
        int lat;

        vecs.push_back('{"divu_100_7",   F_DIVU, 32'd100,       32'd7,         32'd14,        32});
        vecs.push_back('{"remu_100_7",   F_REMU, 32'd100,       32'd7,         32'd2,         32});
        vecs.push_back('{"div_m7_2",     F_DIV,  32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32});
        vecs.push_back('{"rem_m7_2",     F_REM,  32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  32});
        vecs.push_back('{"div_5_0",      F_DIV,  32'd5,         32'd0,         32'hFFFFFFFF,  0});
        vecs.push_back('{"rem_5_0",      F_REM,  32'd5,         32'd0,         32'd5,         0});
        vecs.push_back('{"divu_0_0",     F_DIVU, 32'd0,         32'd0,         32'hFFFFFFFF,  0});
        vecs.push_back('{"remu_7_0",     F_REMU, 32'd7,         32'd0,         32'd7,         0});
        vecs.push_back('{"div_ovf",      F_DIV,  32'h80000000,  32'hFFFFFFFF,  32'h80000000,  0});
        vecs.push_back('{"rem_ovf",      F_REM,  32'h80000000,  32'hFFFFFFFF,  32'd0,         0});
        vecs.push_back('{"divu_ovf_ops", F_DIVU, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32});
        vecs.push_back('{"remu_ovf_ops", F_REMU, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32});
        vecs.push_back('{"div_m100_m7",  F_DIV,  32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32});
        vecs.push_back('{"rem_m100_m7",  F_REM,  32'hFFFFFF9C,  32'hFFFFFFF9,  32'hFFFFFFFE,  32});
        vecs.push_back('{"div_100_m7",   F_DIV,  32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  32});
        vecs.push_back('{"rem_100_m7",   F_REM,  32'd100,       32'hFFFFFFF9,  32'd2,         32});
        vecs.push_back('{"div_min_1",    F_DIV,  32'h80000000,  32'd1,         32'h80000000,  32});
        vecs.push_back('{"rem_min_3",    F_REM,  32'h80000000,  32'd3,         32'hFFFFFFFE,  32});
        vecs.push_back('{"divu_bit2",    3'b101, 32'd100,       32'd7,         32'd14,        32});

        rst_n      = 1'b0;
        flush      = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        func       = 3'd0;
        din1       = 32'd0;
        din2       = 32'd0;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_busy",       {31'd0, busy},       32'd0);
        chk("rst_dout",       dout,                32'd0);
        @(negedge aclk);
        rst_n = 1'b1;
        #1;
        chk("rst_req_ready",  {31'd0, req_ready},  32'd1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Held response, then a second request waiting behind it
        issue(F_DIVU, 32'd100, 32'd7);
        wait_resp(lat);
        chk("hold_lat", 32'(lat), 32'd32);
        @(negedge aclk);
        func      = F_REMU;
        din1      = 32'd100;
        din2      = 32'd7;
        req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge aclk);
            #1;
            chk("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold_dout",       dout,                32'd14);
            chk("hold_req_ready",  {31'd0, req_ready},  32'd0);
        end
        take();
        chk("b2b_idle_after_hs",   {31'd0, busy},      32'd0);
        chk("b2b_ready_after_hs",  {31'd0, req_ready}, 32'd1);
        @(posedge aclk);
        #1;
        req_valid = 1'b0;
        chk("b2b_accepted",        {31'd0, busy},      32'd1);
        wait_resp(lat);
        chk("b2b_lat",  32'(lat), 32'd32);
        chk("b2b_dout", dout,     32'd2);
        take();

        // Flush in IDLE blocks a simultaneous request
        @(negedge aclk);
        flush     = 1'b1;
        req_valid = 1'b1;
        func      = F_DIVU;
        din1      = 32'd9;
        din2      = 32'd3;
        #1;
        chk("flush_idle_ready", {31'd0, req_ready}, 32'd0);
        @(posedge aclk);
        #1;
        chk("flush_idle_busy",  {31'd0, busy},      32'd0);
        flush     = 1'b0;
        req_valid = 1'b0;

        // Flush around iteration 10 drops the op and keeps the old dout
        issue(F_DIVU, 32'd1000, 32'd3);
        repeat (9) begin
            @(posedge aclk);
            #1;
        end
        @(negedge aclk);
        flush = 1'b1;
        @(posedge aclk);
        #1;
        flush = 1'b0;
        chk("flush_calc_busy",  {31'd0, busy}, 32'd0);
        chk("flush_calc_dout",  dout,          32'd2);
        watch_no_resp("flush_calc_no_resp", 40);

        // Reset pulse around iteration 20
        issue(F_DIVU, 32'd1000, 32'd3);
        repeat (19) begin
            @(posedge aclk);
            #1;
        end
        @(negedge aclk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy},       32'd0);
        chk("midrst_rv",   {31'd0, resp_valid}, 32'd0);
        chk("midrst_dout", dout,                32'd0);
        @(negedge aclk);
        rst_n = 1'b1;
        watch_no_resp("midrst_no_resp", 40);

        run_vec('{"divu_ffff_3", F_DIVU, 32'hFFFFFFFF, 32'd3, 32'h55555555, 32});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
